// File: rtl/v2f_alu_arbiter.sv
// Round-robin arbiter time-sharing one external 32-bit ALU bank among N_REQ requesters,
// with fixed-latency tagged result return. Define V2F_ALU_ARB_STATS_EN for issue/error counters.
module v2f_alu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 1,
    parameter int OPW     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*OPW-1:0] req_op,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    output logic                 alu_valid,
    output logic [OPW-1:0]       alu_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_y,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err
`ifdef V2F_ALU_ARB_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [15:0]          stat_err
`endif
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0]    ptr_r;
    logic [N_REQ-1:0] busy_r;
    logic             tag_v_r [LATENCY];
    logic [IW-1:0]    tag_i_r [LATENCY];
    logic             tag_e_r [LATENCY];

    logic [N_REQ-1:0] elig_s;
    logic             found_s;
    logic [IW-1:0]    gnt_idx_s;
    logic [OPW-1:0]   sel_op_s;
    logic [31:0]      sel_a_s;
    logic [31:0]      sel_b_s;
    logic             sel_err_s;

    // Divide/modulo by zero and the unused opcode range never reach the ALU.
    function automatic logic op_err(input logic [OPW-1:0] op, input logic [31:0] b);
        logic is_div;
        is_div = (op == OPW'(3)) || (op == OPW'(4));
        return (is_div && (b == 32'd0)) || (op >= OPW'(10));
    endfunction

    // Returns {found, index} of the first eligible requester at or after ptr, wrapping.
    function automatic logic [IW:0] pick(input logic [N_REQ-1:0] elig, input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int          j;
        res = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end else begin
                j = j;
            end
            if (!res[IW] && elig[IW'(j)]) begin
                res = {1'b1, IW'(j)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Grant selection from registered state; nothing is granted while reset is held.
    always_comb begin
        elig_s = '0;
        if (rst) begin
            elig_s = '0;
        end else begin
            elig_s = req_valid & ~busy_r;
        end
        {found_s, gnt_idx_s} = pick(elig_s, ptr_r);
        req_ready = '0;
        if (found_s) begin
            req_ready[gnt_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign sel_op_s  = req_op[gnt_idx_s*OPW +: OPW];
    assign sel_a_s   = req_a[gnt_idx_s*32 +: 32];
    assign sel_b_s   = req_b[gnt_idx_s*32 +: 32];
    assign sel_err_s = op_err(sel_op_s, sel_b_s);

    // Issue register towards the ALU and round-robin pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_valid <= 1'b0;
            alu_op    <= '0;
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            ptr_r     <= '0;
        end else begin
            alu_valid <= found_s & ~sel_err_s;
            if (found_s) begin
                alu_op <= sel_op_s;
                alu_a  <= sel_a_s;
                alu_b  <= sel_b_s;
                ptr_r  <= (gnt_idx_s == IW'(N_REQ - 1)) ? '0 : gnt_idx_s + IW'(1);
            end else begin
                ptr_r  <= ptr_r;
            end
        end
    end

    // Tag pipeline: carries owner and error flag alongside the ALU's internal stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                tag_v_r[s] <= 1'b0;
                tag_i_r[s] <= '0;
                tag_e_r[s] <= 1'b0;
            end
        end else begin
            tag_v_r[0] <= found_s;
            tag_i_r[0] <= gnt_idx_s;
            tag_e_r[0] <= sel_err_s;
            for (int s = 1; s < LATENCY; s++) begin
                tag_v_r[s] <= tag_v_r[s-1];
                tag_i_r[s] <= tag_i_r[s-1];
                tag_e_r[s] <= tag_e_r[s-1];
            end
        end
    end

    // Response register; data and error hold between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (tag_v_r[LATENCY-1]) begin
                rsp_valid[tag_i_r[LATENCY-1]] <= 1'b1;
                rsp_data <= tag_e_r[LATENCY-1] ? 32'd0 : alu_y;
                rsp_err  <= tag_e_r[LATENCY-1];
            end else begin
                rsp_data <= rsp_data;
                rsp_err  <= rsp_err;
            end
        end
    end

    // Busy stays set through the response cycle, so a requester re-arms one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= (busy_r & ~rsp_valid) | req_ready;
        end
    end

`ifdef V2F_ALU_ARB_STATS_EN
    // Saturating transfer and error-response counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued <= 32'd0;
            stat_err    <= 16'd0;
        end else begin
            if (found_s && (stat_issued != 32'hFFFF_FFFF)) begin
                stat_issued <= stat_issued + 32'd1;
            end else begin
                stat_issued <= stat_issued;
            end
            if (tag_v_r[LATENCY-1] && tag_e_r[LATENCY-1] && (stat_err != 16'hFFFF)) begin
                stat_err <= stat_err + 16'd1;
            end else begin
                stat_err <= stat_err;
            end
        end
    end
`endif

endmodule
